// File: rtl/clint.sv
// Core-local interrupt controller: sequences mepc/mstatus/mcause writes for traps and mstatus restore for mret.
// Optional ecall/ebreak trap detection is compiled in with CLINT_ECALL_EN.
module clint #(
  parameter int CSR_AW = 32,
  parameter int XW     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              int_flag_i,
  input  logic [XW-1:0]     inst_i,
  input  logic [XW-1:0]     inst_addr_i,
  input  logic              jump_flag_i,
  input  logic [XW-1:0]     jump_addr_i,
  input  logic              global_int_en_i,
  input  logic [XW-1:0]     csr_mtvec_i,
  input  logic [XW-1:0]     csr_mepc_i,
  input  logic [XW-1:0]     csr_mstatus_i,
  output logic              we_o,
  output logic [CSR_AW-1:0] waddr_o,
  output logic [XW-1:0]     data_o,
  output logic              hold_flag_o,
  output logic              int_assert_o,
  output logic [XW-1:0]     int_addr_o
);

  typedef enum logic [2:0] {
    IDLE, W_MEPC, W_MSTATUS, W_MCAUSE, ASSERT, MRET_W, MRET_ASSERT
  } state_t;

  localparam logic [XW-1:0] INST_MRET = XW'(32'h3020_0073);

  state_t        r_state, w_state_next;
  logic [XW-1:0] r_cause, w_cause_next;
  logic [XW-1:0] r_epc, w_epc_next;
  logic          w_ecall, w_ebreak, w_mret, w_int, w_go, w_accept;
  logic [XW-1:0] w_mst_trap, w_mst_mret;

`ifdef CLINT_ECALL_EN
  localparam logic [XW-1:0] INST_ECALL  = XW'(32'h0000_0073);
  localparam logic [XW-1:0] INST_EBREAK = XW'(32'h0010_0073);
  assign w_ecall  = (inst_i == INST_ECALL);
  assign w_ebreak = (inst_i == INST_EBREAK);
`else
  assign w_ecall  = 1'b0;
  assign w_ebreak = 1'b0;
`endif

  assign w_mret   = (inst_i == INST_MRET);
  assign w_int    = int_flag_i & global_int_en_i;
  // No event may be latched on a reset edge, so acceptance is gated by rst.
  assign w_go     = (r_state == IDLE) & ~rst;
  assign w_accept = w_go & (w_ecall | w_ebreak | w_mret | w_int);

  always_comb begin
    w_mst_trap    = csr_mstatus_i;
    w_mst_trap[7] = csr_mstatus_i[3];
    w_mst_trap[3] = 1'b0;
    w_mst_mret    = csr_mstatus_i;
    w_mst_mret[3] = csr_mstatus_i[7];
    w_mst_mret[7] = 1'b1;
  end

  always_comb begin
    w_state_next = r_state;
    w_cause_next = r_cause;
    w_epc_next   = r_epc;
    we_o         = 1'b0;
    waddr_o      = '0;
    data_o       = '0;
    hold_flag_o  = 1'b0;
    int_assert_o = 1'b0;
    int_addr_o   = '0;
    case (r_state)
      IDLE: begin
        hold_flag_o = w_accept;
        if (w_go && (w_ecall || w_ebreak)) begin
          w_state_next = W_MEPC;
          w_cause_next = w_ecall ? XW'(32'h0000_000B) : XW'(32'h0000_0003);
          w_epc_next   = inst_addr_i;
        end else if (w_go && w_mret) begin
          w_state_next = MRET_W;
        end else if (w_go && w_int) begin
          w_state_next = W_MEPC;
          w_cause_next = XW'(32'h8000_000B);
          w_epc_next   = jump_flag_i ? jump_addr_i : inst_addr_i;
        end
      end
      W_MEPC: begin
        w_state_next = W_MSTATUS;
        hold_flag_o  = 1'b1;
        we_o         = 1'b1;
        waddr_o      = CSR_AW'(12'h341);
        data_o       = r_epc;
      end
      W_MSTATUS: begin
        w_state_next = W_MCAUSE;
        hold_flag_o  = 1'b1;
        we_o         = 1'b1;
        waddr_o      = CSR_AW'(12'h300);
        data_o       = w_mst_trap;
      end
      W_MCAUSE: begin
        w_state_next = ASSERT;
        hold_flag_o  = 1'b1;
        we_o         = 1'b1;
        waddr_o      = CSR_AW'(12'h342);
        data_o       = r_cause;
      end
      ASSERT: begin
        w_state_next = IDLE;
        int_assert_o = 1'b1;
        int_addr_o   = {csr_mtvec_i[XW-1:2], 2'b00};
      end
      MRET_W: begin
        w_state_next = MRET_ASSERT;
        hold_flag_o  = 1'b1;
        we_o         = 1'b1;
        waddr_o      = CSR_AW'(12'h300);
        data_o       = w_mst_mret;
      end
      MRET_ASSERT: begin
        w_state_next = IDLE;
        int_assert_o = 1'b1;
        int_addr_o   = csr_mepc_i;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cause <= '0;
      r_epc   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cause <= w_cause_next;
      r_epc   <= w_epc_next;
    end
  end

endmodule

// File: tb/tb_clint.sv
// Randomized bench for clint: a transaction-level model predicts the per-cycle output
// sequence of every accepted event; directed cases pin the model with literal values.
module tb_clint;

  logic        clk = 1'b0;
  logic        rst;
  logic        int_flag_i;
  logic [31:0] inst_i, inst_addr_i, jump_addr_i;
  logic        jump_flag_i, global_int_en_i;
  logic [31:0] csr_mtvec_i, csr_mepc_i, csr_mstatus_i;
  logic        we_o, hold_flag_o, int_assert_o;
  logic [31:0] waddr_o, data_o, int_addr_o;

  always #5 clk = ~clk;

  clint dut (
    .clk(clk), .rst(rst), .int_flag_i(int_flag_i), .inst_i(inst_i),
    .inst_addr_i(inst_addr_i), .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .global_int_en_i(global_int_en_i), .csr_mtvec_i(csr_mtvec_i),
    .csr_mepc_i(csr_mepc_i), .csr_mstatus_i(csr_mstatus_i),
    .we_o(we_o), .waddr_o(waddr_o), .data_o(data_o), .hold_flag_o(hold_flag_o),
    .int_assert_o(int_assert_o), .int_addr_o(int_addr_o)
  );

  typedef struct packed {
    logic        hold;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] data;
    logic        ia;
    logic [31:0] iaddr;
  } outv_t;

  outv_t q[$];
  int    n_checks = 0;
  int    n_err    = 0;
  bit    armed    = 0;

  function automatic outv_t mk(logic h, logic w, logic [31:0] wa, logic [31:0] d,
                               logic ia, logic [31:0] iad);
    outv_t o;
    o = {h, w, wa, d, ia, iad};
    return o;
  endfunction

  // Reference model: whenever the controller is idle, decide which event the
  // current inputs represent and queue the exact outputs of the following cycles.
  always @(negedge clk) begin
    outv_t       e, a;
    int          ev;
    logic [31:0] pc, cause, m;
    if (armed) begin
      a = {hold_flag_o, we_o, waddr_o, data_o, int_assert_o, int_addr_o};
      if (q.size() > 0) begin
        e = q.pop_front();
      end else begin
        e = '0;
        ev = 0;
        pc = 0;
        cause = 0;
        if (!rst) begin
`ifdef CLINT_ECALL_EN
          if (inst_i == 32'h0000_0073) begin ev = 1; cause = 32'hB; pc = inst_addr_i; end
          else if (inst_i == 32'h0010_0073) begin ev = 1; cause = 32'h3; pc = inst_addr_i; end
`endif
          if (ev == 0) begin
            if (inst_i == 32'h3020_0073) ev = 2;
            else if (int_flag_i && global_int_en_i) begin
              ev = 1;
              cause = 32'h8000_000B;
              pc = jump_flag_i ? jump_addr_i : inst_addr_i;
            end
          end
        end
        if (ev == 1) begin
          e.hold = 1'b1;
          m = csr_mstatus_i & ~32'h88;
          m = m | (((csr_mstatus_i >> 3) & 32'h1) << 7);
          q.push_back(mk(1, 1, 32'h341, pc, 0, 0));
          q.push_back(mk(1, 1, 32'h300, m, 0, 0));
          q.push_back(mk(1, 1, 32'h342, cause, 0, 0));
          q.push_back(mk(0, 0, 0, 0, 1, csr_mtvec_i & ~32'h3));
          $display("txn trap t=%0t cause=%08h epc=%08h", $time, cause, pc);
        end else if (ev == 2) begin
          e.hold = 1'b1;
          m = (csr_mstatus_i & ~32'h8) | (((csr_mstatus_i >> 7) & 32'h1) << 3) | 32'h80;
          q.push_back(mk(1, 1, 32'h300, m, 0, 0));
          q.push_back(mk(0, 0, 0, 0, 1, csr_mepc_i));
          $display("txn mret t=%0t mepc=%08h", $time, csr_mepc_i);
        end
      end
      if (rst) q.delete();
      n_checks++;
      if (a !== e) begin
        n_err++;
        $display("FAIL cycle_outputs t=%0t got h=%0b we=%0b wa=%h d=%h ia=%0b ia_addr=%h want h=%0b we=%0b wa=%h d=%h ia=%0b ia_addr=%h",
                 $time, a.hold, a.we, a.waddr, a.data, a.ia, a.iaddr,
                 e.hold, e.we, e.waddr, e.data, e.ia, e.iaddr);
      end
    end
  end

  task automatic lit(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, req);
    end
  endtask

  task automatic chk(string name, logic h, logic w, logic [31:0] wa, logic [31:0] d,
                     logic ia, logic [31:0] iad);
    @(negedge clk);
    lit({name, ".hold"}, 32'(hold_flag_o), 32'(h));
    lit({name, ".we"}, 32'(we_o), 32'(w));
    lit({name, ".waddr"}, waddr_o, wa);
    lit({name, ".data"}, data_o, d);
    lit({name, ".int_assert"}, 32'(int_assert_o), 32'(ia));
    lit({name, ".int_addr"}, int_addr_o, iad);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    int_flag_i = 0; global_int_en_i = 0; inst_i = 32'h13; jump_flag_i = 0;
  endtask

  initial begin
    rst = 1; quiet(); inst_addr_i = 0; jump_addr_i = 0;
    csr_mtvec_i = 0; csr_mepc_i = 0; csr_mstatus_i = 0;
    cyc();
    armed = 1;
    chk("reset", 0, 0, 0, 0, 0, 0);

    // Interrupt at PC 0x100, mtvec 0x200, MIE set.
    cyc(); rst = 0; int_flag_i = 1; global_int_en_i = 1; inst_addr_i = 32'h100;
    csr_mtvec_i = 32'h200; csr_mstatus_i = 32'h8;
    chk("irq_accept", 1, 0, 0, 0, 0, 0);
    cyc(); quiet(); chk("irq_mepc", 1, 1, 32'h341, 32'h100, 0, 0);
    cyc(); chk("irq_mstatus", 1, 1, 32'h300, 32'h80, 0, 0);
    cyc(); chk("irq_mcause", 1, 1, 32'h342, 32'h8000_000B, 0, 0);
    cyc(); chk("irq_assert", 0, 0, 0, 0, 1, 32'h200);
    cyc(); chk("irq_idle", 0, 0, 0, 0, 0, 0);

    // Interrupt during a jump: mepc takes the jump target.
    cyc(); int_flag_i = 1; global_int_en_i = 1; jump_flag_i = 1; jump_addr_i = 32'h40;
    csr_mtvec_i = 32'h203;
    chk("jmp_accept", 1, 0, 0, 0, 0, 0);
    cyc(); quiet(); chk("jmp_mepc", 1, 1, 32'h341, 32'h40, 0, 0);
    cyc(); cyc(); cyc(); chk("jmp_assert", 0, 0, 0, 0, 1, 32'h200);

    // mret restores MIE from MPIE.
    cyc(); inst_i = 32'h3020_0073; csr_mstatus_i = 32'h80; csr_mepc_i = 32'h104;
    chk("mret_accept", 1, 0, 0, 0, 0, 0);
    cyc(); quiet(); chk("mret_w", 1, 1, 32'h300, 32'h88, 0, 0);
    cyc(); chk("mret_assert", 0, 0, 0, 0, 1, 32'h104);

    // ecall together with a pending interrupt.
    cyc(); inst_i = 32'h0000_0073; inst_addr_i = 32'h80; int_flag_i = 1; global_int_en_i = 1;
    csr_mstatus_i = 32'h8; csr_mtvec_i = 32'h300;
    chk("ecall_accept", 1, 0, 0, 0, 0, 0);
    cyc(); chk("ecall_mepc", 1, 1, 32'h341, 32'h80, 0, 0);
    cyc(); chk("ecall_mstatus", 1, 1, 32'h300, 32'h80, 0, 0);
`ifdef CLINT_ECALL_EN
    cyc(); chk("ecall_mcause", 1, 1, 32'h342, 32'hB, 0, 0);
`else
    cyc(); chk("ecall_mcause", 1, 1, 32'h342, 32'h8000_000B, 0, 0);
`endif
    cyc(); chk("ecall_assert", 0, 0, 0, 0, 1, 32'h300);
    cyc(); quiet();

    // Reset in W_MSTATUS abandons the sequence.
    cyc(); int_flag_i = 1; global_int_en_i = 1; inst_addr_i = 32'h500;
    chk("rst_accept", 1, 0, 0, 0, 0, 0);
    cyc(); quiet(); chk("rst_mepc", 1, 1, 32'h341, 32'h500, 0, 0);
    cyc(); rst = 1; chk("rst_mstatus", 1, 1, 32'h300, 32'h80, 0, 0);
    cyc(); rst = 0; chk("rst_after1", 0, 0, 0, 0, 0, 0);
    cyc(); chk("rst_after2", 0, 0, 0, 0, 0, 0);

    // Masked interrupt: no activity.
    cyc(); int_flag_i = 1; global_int_en_i = 0; chk("masked1", 0, 0, 0, 0, 0, 0);
    cyc(); chk("masked2", 0, 0, 0, 0, 0, 0);
    cyc(); quiet();

    for (int i = 0; i < 1500; i++) begin
      cyc();
      rst = ($urandom_range(0, 59) == 0);
      int_flag_i = 1'($urandom);
      global_int_en_i = 1'($urandom);
      case ($urandom_range(0, 5))
        0: inst_i = 32'h0000_0073;
        1: inst_i = 32'h0010_0073;
        2: inst_i = 32'h3020_0073;
        default: inst_i = $urandom;
      endcase
      inst_addr_i = $urandom & ~32'h3;
      jump_flag_i = 1'($urandom);
      jump_addr_i = $urandom & ~32'h3;
      if (q.size() == 0) begin
        csr_mtvec_i = $urandom;
        csr_mepc_i = $urandom;
        csr_mstatus_i = $urandom;
      end
    end
    cyc(); rst = 1; quiet();
    cyc(); cyc();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/clint.md
CLINT -- requirements
Module: clint

Interface
REQ-001 SHALL have parameter CSR_AW, default 32, meaning CSR address width; only bits [11:0] are significant.
REQ-002 SHALL have parameter XW, default 32, meaning data and instruction-address width.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port int_flag_i  input  1  external interrupt request, level.
REQ-006 SHALL have port inst_i  input  XW  instruction currently in ex.
REQ-007 SHALL have port inst_addr_i  input  XW  PC of inst_i.
REQ-008 SHALL have port jump_flag_i  input  1  ex is redirecting the PC this cycle.
REQ-009 SHALL have port jump_addr_i  input  XW  redirect target.
REQ-010 SHALL have port global_int_en_i  input  1  mstatus.MIE from the CSR file.
REQ-011 SHALL have port csr_mtvec_i / csr_mepc_i / csr_mstatus_i  input  XW each  current CSR values.
REQ-012 SHALL have port we_o  output  1  CSR write enable.
REQ-013 SHALL have port waddr_o  output  CSR_AW  CSR write address.
REQ-014 SHALL have port data_o  output  XW  CSR write data.
REQ-015 SHALL have port hold_flag_o  output  1  stall whole pipeline.
REQ-016 SHALL have port int_assert_o  output  1  one-cycle PC redirect strobe.
REQ-017 SHALL have port int_addr_o  output  XW  redirect target, valid with int_assert_o.

Function
REQ-018 SHALL implement FSM states IDLE, W_MEPC, W_MSTATUS, W_MCAUSE, ASSERT, MRET_W, MRET_ASSERT.
REQ-019 SHALL, in IDLE, accept exactly one event per cycle with priority ecall/ebreak > mret (inst_i==0x30200073) > interrupt (int_flag_i & global_int_en_i).
REQ-020 SHALL, on an accepted interrupt, latch mcause=0x8000000B and return PC = jump_addr_i if jump_flag_i else inst_addr_i.
REQ-021 SHALL, on ecall (0x00000073), latch mcause=0x0000000B; on ebreak (0x00100073), latch mcause=0x00000003; in both cases return PC = inst_addr_i.
REQ-022 SHALL, for a trap, sequence W_MEPC (waddr 0x341, data=return PC) -> W_MSTATUS (waddr 0x300, data=mstatus with bit7=old bit3 and bit3=0) -> W_MCAUSE (waddr 0x342, data=latched cause) -> ASSERT -> IDLE; each state lasts exactly one cycle.
REQ-023 SHALL, in ASSERT, drive int_assert_o=1 and int_addr_o=csr_mtvec_i with bits[1:0] forced to 0, with we_o=0.
REQ-024 SHALL, for mret, sequence MRET_W (waddr 0x300, data=mstatus with bit3=old bit7 and bit7=1) -> MRET_ASSERT (int_assert_o=1, int_addr_o=csr_mepc_i) -> IDLE.
REQ-025 SHALL drive hold_flag_o combinationally high in the event-accept cycle and in every non-IDLE state except the final assert states; total trap latency is 4 cycles from accept to int_assert_o.
REQ-026 SHALL assert we_o only in W_MEPC, W_MSTATUS, W_MCAUSE and MRET_W; otherwise we_o=0, waddr_o=0, data_o=0.
REQ-027 SHALL ignore int_flag_i and inst_i while not in IDLE; an interrupt still pending at IDLE re-entry is gated by the updated global_int_en_i.
REQ-028 SHALL drive int_assert_o=0 and int_addr_o=0 outside the assert states.

Reset
REQ-029 SHALL, on rst high at any clock edge including mid-sequence, enter IDLE and clear latched cause and return PC; all outputs are 0 in the cycle after the edge and no partial CSR sequence resumes.

Configuration
REQ-030 SHALL compile ecall/ebreak trap detection only when CLINT_ECALL_EN is defined; without it, those encodings are ignored and only interrupt and mret are handled.

Verification
REQ-031 SHALL cover: MIE=1, int_flag_i=1, inst_addr_i=0x100, mtvec=0x200 -> writes 0x341=0x100, 0x300 (MIE=0, MPIE=1), 0x342=0x8000000B on cycles 1-3, then int_assert_o with int_addr_o=0x200 on cycle 4.
REQ-032 SHALL cover: interrupt with jump_flag_i=1 and jump_addr_i=0x40 -> mepc written 0x40.
REQ-033 SHALL cover: inst_i=0x30200073, mstatus=0x80, mepc=0x104 -> mstatus written 0x88, then int_assert_o with int_addr_o=0x104.
REQ-034 SHALL cover: with CLINT_ECALL_EN, inst_i=0x00000073 at 0x80 with int_flag_i=1 simultaneously -> mcause=0xB and mepc=0x80; the interrupt is not taken during the sequence.
REQ-035 SHALL cover: rst asserted in W_MSTATUS -> no W_MCAUSE write, no int_assert_o, IDLE next cycle; MIE=0 with int_flag_i=1 -> no activity.
